// File: rtl/alu_pkg.sv
// Shared definitions for the execute-stage ALU: op codes, ALUOp encodings,
// FSM states and the base funct3 map used by R-type and I-type decode.
package alu_pkg;

  localparam logic [3:0] OP_AND     = 4'b0000;
  localparam logic [3:0] OP_OR      = 4'b0001;
  localparam logic [3:0] OP_ADD     = 4'b0010;
  localparam logic [3:0] OP_XOR     = 4'b0011;
  localparam logic [3:0] OP_SLL     = 4'b0100;
  localparam logic [3:0] OP_SRL     = 4'b0101;
  localparam logic [3:0] OP_SUB     = 4'b0110;
  localparam logic [3:0] OP_SLT     = 4'b0111;
  localparam logic [3:0] OP_SRA     = 4'b1000;
  localparam logic [3:0] OP_SLTU    = 4'b1001;
  localparam logic [3:0] OP_MUL     = 4'b1010;
  localparam logic [3:0] OP_ILLEGAL = 4'b1111;

  localparam logic [1:0] ALU_OP_MEM    = 2'b00;
  localparam logic [1:0] ALU_OP_BRANCH = 2'b01;
  localparam logic [1:0] ALU_OP_RTYPE  = 2'b10;
  localparam logic [1:0] ALU_OP_ITYPE  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_BUSY = 2'b01,
    ST_DONE = 2'b10
  } state_e;

  // funct3 map shared by R-type (funct7 bits clear) and I-type
  function automatic logic [3:0] base_op(input logic [2:0] funct3);
    logic [3:0] op;
    case (funct3)
      3'b000:  op = OP_ADD;
      3'b001:  op = OP_SLL;
      3'b010:  op = OP_SLT;
      3'b011:  op = OP_SLTU;
      3'b100:  op = OP_XOR;
      3'b101:  op = OP_SRL;
      3'b110:  op = OP_OR;
      3'b111:  op = OP_AND;
      default: op = OP_ILLEGAL;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/alu_ctrl_dec.sv
// Combinational ALU control decode: ALUOp plus funct fields to a 4-bit op code.
module alu_ctrl_dec
  import alu_pkg::*;
(
  input  logic [1:0] alu_op,
  input  logic [2:0] funct3,
  input  logic       funct7_5,
  input  logic       funct7_0,
  output logic [3:0] op
);

  // Decode table; anything not explicitly mapped becomes ILLEGAL
  always_comb begin
    op = OP_ILLEGAL;
    case (alu_op)
      ALU_OP_MEM:    op = OP_ADD;
      ALU_OP_BRANCH: op = OP_SUB;
      ALU_OP_RTYPE: begin
        if (funct7_0) begin
          // M-extension: only MUL is supported
          if (!funct7_5 && (funct3 == 3'b000)) begin
            op = OP_MUL;
          end else begin
            op = OP_ILLEGAL;
          end
        end else if (funct7_5) begin
          case (funct3)
            3'b000:  op = OP_SUB;
            3'b101:  op = OP_SRA;
            default: op = OP_ILLEGAL;
          endcase
        end else begin
          op = base_op(funct3);
        end
      end
      ALU_OP_ITYPE: begin
        // bit 30 is part of the immediate except for shifts
        if (funct3 == 3'b000) begin
          op = OP_ADD;
        end else if ((funct3 == 3'b101) && funct7_5) begin
          op = OP_SRA;
        end else if ((funct3 == 3'b001) && funct7_5) begin
          op = OP_ILLEGAL;
        end else begin
          op = base_op(funct3);
        end
      end
      default: op = OP_ILLEGAL;
    endcase
  end

endmodule

// File: rtl/alu_exec_unit.sv
// Execute-stage unit: decoded single-cycle ALU plus an iterative multiplier,
// fronted and backed by a valid/ready handshake.
module alu_exec_unit
  import alu_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int MUL_STEP = 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [1:0]      alu_op,
  input  logic [2:0]      funct3,
  input  logic            funct7_5,
  input  logic            funct7_0,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic [3:0]      operation,
  output logic            illegal
);

  localparam int SHW   = $clog2(XLEN);
  localparam int STEPS = XLEN / MUL_STEP;
  localparam int CNT_W = (STEPS > 1) ? $clog2(STEPS) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(STEPS - 1);

  state_e            state_r;
  logic [XLEN-1:0]   result_r;
  logic [3:0]        operation_r;
  logic              illegal_r;
  logic              out_valid_r;
  logic [XLEN-1:0]   mcand_r;
  logic [XLEN-1:0]   mplier_r;
  logic [XLEN-1:0]   acc_r;
  logic [CNT_W-1:0]  cnt_r;

  logic [3:0]        dec_op_s;
  logic              accept_s;
  logic [XLEN-1:0]   alu_res_s;
  logic [XLEN-1:0]   acc_next_s;

  // Single-cycle ALU; MUL and ILLEGAL yield zero here
  function automatic logic [XLEN-1:0] alu_compute(input logic [3:0]      op,
                                                  input logic [XLEN-1:0] x,
                                                  input logic [XLEN-1:0] y);
    logic [SHW-1:0]  shamt;
    logic [XLEN-1:0] r;
    shamt = y[SHW-1:0];
    case (op)
      OP_AND:  r = x & y;
      OP_OR:   r = x | y;
      OP_ADD:  r = x + y;
      OP_XOR:  r = x ^ y;
      OP_SLL:  r = x << shamt;
      OP_SRL:  r = x >> shamt;
      OP_SUB:  r = x - y;
      OP_SLT:  r = {{(XLEN-1){1'b0}}, ($signed(x) < $signed(y))};
      OP_SRA:  r = $signed(x) >>> shamt;
      OP_SLTU: r = {{(XLEN-1){1'b0}}, (x < y)};
      default: r = {XLEN{1'b0}};
    endcase
    return r;
  endfunction

  // Partial product of the multiplicand with MUL_STEP multiplier bits
  function automatic logic [XLEN-1:0] partial_product(input logic [XLEN-1:0]     mcand,
                                                      input logic [MUL_STEP-1:0] bits);
    logic [XLEN-1:0] sum;
    sum = {XLEN{1'b0}};
    for (int j = 0; j < MUL_STEP; j++) begin
      if (bits[j]) begin
        sum = sum + (mcand << j);
      end else begin
        sum = sum;
      end
    end
    return sum;
  endfunction

  alu_ctrl_dec u_dec (
    .alu_op   (alu_op),
    .funct3   (funct3),
    .funct7_5 (funct7_5),
    .funct7_0 (funct7_0),
    .op       (dec_op_s)
  );

  assign in_ready = (state_r == ST_IDLE) || ((state_r == ST_DONE) && out_ready);
  assign accept_s = in_valid && in_ready;

  // Single-cycle result for the op being presented
  always_comb begin
    alu_res_s = alu_compute(dec_op_s, a, b);
  end

  // Accumulator value after retiring the next MUL_STEP multiplier bits
  always_comb begin
    acc_next_s = acc_r + partial_product(mcand_r, mplier_r[MUL_STEP-1:0]);
  end

  // Control FSM with registered result, op code, illegal flag and multiplier state
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= ST_IDLE;
      out_valid_r <= 1'b0;
      result_r    <= {XLEN{1'b0}};
      operation_r <= 4'b0000;
      illegal_r   <= 1'b0;
      mcand_r     <= {XLEN{1'b0}};
      mplier_r    <= {XLEN{1'b0}};
      acc_r       <= {XLEN{1'b0}};
      cnt_r       <= {CNT_W{1'b0}};
    end else if (accept_s) begin
      // Accept is only possible from IDLE or from DONE with the result taken
      operation_r <= dec_op_s;
      if (dec_op_s == OP_MUL) begin
        state_r     <= ST_BUSY;
        out_valid_r <= 1'b0;
        illegal_r   <= 1'b0;
        mcand_r     <= a;
        mplier_r    <= b;
        acc_r       <= {XLEN{1'b0}};
        cnt_r       <= {CNT_W{1'b0}};
      end else begin
        state_r     <= ST_DONE;
        out_valid_r <= 1'b1;
        result_r    <= alu_res_s;
        illegal_r   <= (dec_op_s == OP_ILLEGAL);
      end
    end else begin
      case (state_r)
        ST_IDLE: begin
          out_valid_r <= 1'b0;
        end
        ST_BUSY: begin
          acc_r    <= acc_next_s;
          mcand_r  <= mcand_r << MUL_STEP;
          mplier_r <= mplier_r >> MUL_STEP;
          cnt_r    <= cnt_r + CNT_W'(1);
          if (cnt_r == LAST_CNT) begin
            state_r     <= ST_DONE;
            out_valid_r <= 1'b1;
            result_r    <= acc_next_s;
          end
        end
        ST_DONE: begin
          // Without out_ready everything simply holds
          if (out_ready) begin
            state_r     <= ST_IDLE;
            out_valid_r <= 1'b0;
          end
        end
        default: begin
          state_r     <= ST_IDLE;
          out_valid_r <= 1'b0;
        end
      endcase
    end
  end

  assign out_valid = out_valid_r;
  assign result    = result_r;
  assign operation = operation_r;
  assign illegal   = illegal_r;

endmodule
